// File: rtl/serdes_pkg.sv
// Shared types and constants for the serdes receive/transmit blocks.
// Holds the alignment FSM states, the default comma and a width helper.
package serdes_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Number of bits needed to count 0..n-1 (minimum 1).
  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational comma window: the last SYM serial bits including the bit
// currently on the line, and a flag when they form the K=1 comma symbol.
module comma_detect
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_DEFAULT)
) (
  input  logic [WIDTH-1:0] sr_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   win_o,
  output logic             match_o
);

  assign win_o   = {sr_i, bit_i};
  assign match_o = (win_o == {1'b1, COMMA});

endmodule

// File: rtl/deserializer_align.sv
// Serial-to-parallel converter with comma-based word alignment: hunts for
// the comma, tracks symbol boundaries while locked, drops lock on slips.
module deserializer_align
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(COMMA_DEFAULT),
  parameter int unsigned      MISALIGN_MAX = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             k_out,
  output logic             valid_out,
  output logic             locked
);

  localparam int unsigned      SYM       = WIDTH + 1;
  localparam int               CNT_W     = clog2(SYM);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SYM - 1);
  localparam int               MIS_W     = 4;
  localparam logic [MIS_W-1:0] MIS_LIMIT = MIS_W'(MISALIGN_MAX);

  if (MISALIGN_MAX == 0 || MISALIGN_MAX > 15) begin : g_bad_misalign_max
    $error("deserializer_align: MISALIGN_MAX must be in 1..15");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("deserializer_align: WIDTH must be at least 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [MIS_W-1:0] misalign_q;
  logic [WIDTH-1:0] data_q;
  logic             k_q;
  logic             valid_q;
  logic             locked_q;

  logic [WIDTH:0]   win;
  logic             match;
  logic             boundary;
  logic [MIS_W-1:0] misalign_inc;

  comma_detect #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_comma_detect (
    .sr_i    (sr_q),
    .bit_i   (data_in),
    .win_o   (win),
    .match_o (match)
  );

  assign boundary     = (bit_cnt_q == LAST_BIT);
  assign misalign_inc = misalign_q + MIS_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      misalign_q <= '0;
      data_q     <= '0;
      k_q        <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      // The low WIDTH bits of the window are exactly the shifted register.
      sr_q    <= win[WIDTH-1:0];
      valid_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (match) begin
            state_q    <= LOCKED;
            bit_cnt_q  <= '0;
            misalign_q <= '0;
            valid_q    <= 1'b1;
            data_q     <= COMMA;
            k_q        <= 1'b1;
            locked_q   <= 1'b1;
          end
        end
        LOCKED: begin
          bit_cnt_q <= boundary ? '0 : bit_cnt_q + CNT_W'(1);
          if (boundary) begin
            valid_q <= 1'b1;
            data_q  <= win[WIDTH-1:0];
            k_q     <= win[WIDTH];
            if (match) misalign_q <= '0;
          end else if (match) begin
            // A comma off the boundary means the stream has slipped.
            if (misalign_inc == MIS_LIMIT) begin
              state_q    <= HUNT;
              locked_q   <= 1'b0;
              misalign_q <= '0;
              bit_cnt_q  <= '0;
            end else begin
              misalign_q <= misalign_inc;
            end
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign k_out     = k_q;
  assign valid_out = valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_deserializer_align.sv
// Directed bench for deserializer_align: reset, acquisition, steady stream,
// loss of lock, recovery and asynchronous reset mid-symbol.
module tb_deserializer_align;

  localparam int W = 8;
  localparam logic [W-1:0] COMMA_D = 8'hBC;

  logic         clk     = 1'b0;
  logic         reset_L = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] data_out;
  logic         k_out;
  logic         valid_out;
  logic         locked;

  int   n_checks    = 0;
  int   n_pass      = 0;
  int   pulses      = 0;
  logic locked_seen = 1'b0;

  deserializer_align #(
    .WIDTH        (W),
    .COMMA        (COMMA_D),
    .MISALIGN_MAX (2)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out),
    .k_out     (k_out),
    .valid_out (valid_out),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one bit, let the rising edge take it, then observe 1 ns later.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
    if (valid_out) pulses++;
    if (locked) locked_seen = 1'b1;
  endtask

  task automatic send_sym(input logic k, input logic [W-1:0] d);
    logic [W:0] s;
    s = {k, d};
    for (int i = W; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic check_emit(input string tag, input logic k, input logic [W-1:0] d);
    check({tag, "_valid"}, valid_out, 1'b1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_k"}, k_out, k);
  endtask

  initial begin
    logic [W:0] pat;
    logic [W-1:0] dval;

    // 1. reset held with toggling input, then comma-free 0x55 traffic
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = ~data_in;
      @(posedge clk);
      #1;
    end
    check("rst_data", data_out, '0);
    check("rst_k", k_out, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_locked", locked, 1'b0);
    reset_L = 1'b1;
    pulses = 0;
    locked_seen = 1'b0;
    pat = {1'b0, 8'h55};
    for (int i = 0; i < 40; i++) send_bit(pat[W - (i % (W + 1))]);
    check("idle_pulses", pulses, 0);
    check("idle_locked", locked_seen, 1'b0);

    // 2. acquisition: junk, comma, then data 0xA5
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_sym(1'b1, COMMA_D);
    check_emit("acq_comma", 1'b1, COMMA_D);
    check("acq_locked", locked, 1'b1);
    pulses = 0;
    send_sym(1'b0, 8'hA5);
    check("acq_a5_pulses", pulses, 1);
    check_emit("acq_a5", 1'b0, 8'hA5);

    // 3. steady stream: commas at positions 0 and 10, data 0x00..0x11 elsewhere
    dval = 8'h00;
    for (int j = 0; j < 20; j++) begin
      pulses = 0;
      if (j == 0 || j == 10) begin
        send_sym(1'b1, COMMA_D);
        check("str_pulses", pulses, 1);
        check_emit("str_comma", 1'b1, COMMA_D);
      end else begin
        send_sym(1'b0, dval);
        check("str_pulses", pulses, 1);
        check_emit("str_data", 1'b0, dval);
        dval = dval + 8'h01;
      end
      check("str_locked", locked, 1'b1);
    end

    // 4. 3-bit slip then two misaligned commas drop lock; third relocks
    send_zeros(3);
    send_sym(1'b1, COMMA_D);
    check("slip_first_locked", locked, 1'b1);
    send_sym(1'b1, COMMA_D);
    check("slip_second_locked", locked, 1'b0);
    check("slip_second_valid", valid_out, 1'b0);
    send_sym(1'b1, COMMA_D);
    check_emit("relock", 1'b1, COMMA_D);
    check("relock_locked", locked, 1'b1);
    pulses = 0;
    send_sym(1'b0, 8'hA5);
    check("relock_a5_pulses", pulses, 1);
    check_emit("relock_a5", 1'b0, 8'hA5);

    // 5. one misaligned comma, aligned comma clears count, another single slip
    send_zeros(3);
    send_sym(1'b1, COMMA_D);
    check("rec_mis1_locked", locked, 1'b1);
    send_zeros(6);
    send_sym(1'b1, COMMA_D);
    check_emit("rec_aligned", 1'b1, COMMA_D);
    send_zeros(3);
    send_sym(1'b1, COMMA_D);
    check("rec_mis2_locked", locked, 1'b1);
    send_zeros(9);
    check("rec_hold_locked", locked, 1'b1);

    // 6. realign, then asynchronous reset four bits into a symbol
    send_zeros(6);
    send_sym(1'b1, COMMA_D);
    check_emit("mid_realign", 1'b1, COMMA_D);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid_rst_data", data_out, '0);
    check("mid_rst_k", k_out, 1'b0);
    check("mid_rst_valid", valid_out, 1'b0);
    check("mid_rst_locked", locked, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    pulses = 0;
    locked_seen = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int j = 0; j < 3; j++) send_sym(1'b0, 8'hA5);
    check("post_rst_pulses", pulses, 0);
    check("post_rst_locked", locked_seen, 1'b0);
    send_sym(1'b1, COMMA_D);
    check_emit("post_rst_relock", 1'b1, COMMA_D);
    check("post_rst_locked_now", locked, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
